// File: rtl/seq_normalizer_if.sv
// Handshake bundle for seq_normalizer: operand request and normalized result.
//   in_valid/in_ready : operand handshake; a = operand, s0 = direction (1 = right)
//   out_valid/out_ready : result handshake; b = normalized word, amt = shift amount,
//                         zero = operand was all zeros
// Modports: slave = normalizer side, master = producer/consumer side.
interface seq_normalizer_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = $clog2(N)
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic          s0;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  b;
  logic [AW-1:0] amt;
  logic          zero;

  modport slave (
    input  in_valid, a, s0, out_ready,
    output in_ready, out_valid, b, amt, zero
  );

  modport master (
    output in_valid, a, s0, out_ready,
    input  in_ready, out_valid, b, amt, zero
  );
endinterface

// File: rtl/seq_normalizer.sv
// seq_normalizer: iterative normalizer. Left mode (s0=0) shifts the operand left
// until its MSB is 1 (leading-zero count); right mode (s0=1) shifts right until
// its LSB is 1 (trailing-zero count). Returns normalized word, amount, zero flag.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_normalizer_if.slave (operand in, result out, valid/ready each side)
// Optional build macro SEQ_NORM_DOUBLE_STEP_EN: skip two zero bits per cycle
// when possible; results are unchanged, only latency shrinks.
module seq_normalizer #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_normalizer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_w;
  logic          r_dir;
  logic [AW-1:0] r_cnt;
  logic          r_zf;

  logic          w_accept;
  logic          w_is_zero;
  logic          w_target;
`ifdef SEQ_NORM_DOUBLE_STEP_EN
  logic          w_pair_zero;
`endif

  assign w_accept  = bus.in_valid && (r_state == S_IDLE);
  assign w_is_zero = (r_w == '0);
  // Bit that must become 1 for the word to count as normalized.
  assign w_target  = r_dir ? r_w[0] : r_w[N-1];
`ifdef SEQ_NORM_DOUBLE_STEP_EN
  // Target bit and its inward neighbour both clear: a 2-bit shift cannot overshoot.
  assign w_pair_zero = r_dir ? (r_w[1:0] == 2'b00) : (r_w[N-1:N-2] == 2'b00);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)             w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_is_zero || w_target)    w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready)            w_state_nxt = S_IDLE;
      default:                               w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      S_IDLE:  bus.in_ready  = 1'b1;
      S_DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Working register, direction, shift counter and zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w   <= '0;
      r_dir <= 1'b0;
      r_cnt <= '0;
      r_zf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_w   <= bus.a;
            r_dir <= bus.s0;
            r_cnt <= '0;
            r_zf  <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_is_zero) begin
            r_zf  <= 1'b1;
            r_cnt <= '0;
          end else if (!w_target) begin
`ifdef SEQ_NORM_DOUBLE_STEP_EN
            if (w_pair_zero) begin
              r_w   <= r_dir ? (r_w >> 2) : (r_w << 2);
              r_cnt <= AW'(r_cnt + AW'(2));
            end else begin
              r_w   <= r_dir ? (r_w >> 1) : (r_w << 1);
              r_cnt <= AW'(r_cnt + AW'(1));
            end
`else
            r_w   <= r_dir ? (r_w >> 1) : (r_w << 1);
            r_cnt <= AW'(r_cnt + AW'(1));
`endif
          end
        end
        default: ;  // DONE holds the result until the consumer takes it
      endcase
    end
  end

  assign bus.b    = r_w;
  assign bus.amt  = r_cnt;
  assign bus.zero = r_zf;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed self-checking bench for seq_normalizer (N=8).
module tb_seq_normalizer;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;
`ifdef SEQ_NORM_DOUBLE_STEP_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  seq_normalizer_if #(.N(N), .AW(AW)) bus ();

  seq_normalizer #(.N(N), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected cycles from the accepting edge to out_valid.
  function automatic int exp_lat(input int k, input bit z);
    if (z)       return 1;
    else if (DS) return (k + 1) / 2 + 1;
    else         return k + 1;
  endfunction

  function automatic int clz8(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return 7 - i;
    return 0;
  endfunction

  // Offer one operand; returns after the accepting edge (+1).
  task automatic start_op(input logic [7:0] av, input logic sv);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.s0       = sv;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid with a cycle budget; lat = edges after the accepting edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) begin
      n_total++;
      $display("FAIL timeout: out_valid never rose within %0d cycles", lat);
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // One full operation with inline checks of result and latency.
  task automatic run_vec(input string nm, input logic [7:0] av, input logic sv,
                         input logic [7:0] eb, input logic [AW-1:0] eamt, input logic ez);
    int lat;
    start_op(av, sv);
    wait_done(lat);
    n_total++;
    if (bus.b !== eb) $display("FAIL %s b: got %h want %h", nm, bus.b, eb);
    else n_pass++;
    n_total++;
    if (bus.amt !== eamt) $display("FAIL %s amt: got %0d want %0d", nm, bus.amt, eamt);
    else n_pass++;
    n_total++;
    if (bus.zero !== ez) $display("FAIL %s zero: got %b want %b", nm, bus.zero, ez);
    else n_pass++;
    n_total++;
    if (lat != exp_lat(int'(eamt), ez))
      $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat(int'(eamt), ez));
    else n_pass++;
    finish_op();
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if ({bus.in_ready, bus.out_valid, bus.b, bus.amt, bus.zero} !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0})
      $display("FAIL reset_asserted: got rdy=%b vld=%b b=%h amt=%0d z=%b want 1 0 00 0 0",
               bus.in_ready, bus.out_valid, bus.b, bus.amt, bus.zero);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10)
      $display("FAIL reset_released: got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_left();
    run_vec("left_16", 8'b0001_0110, 1'b0, 8'b1011_0000, 3'd3, 1'b0);
    run_vec("left_40", 8'h40, 1'b0, 8'h80, 3'd1, 1'b0);
  endtask

  task automatic test_right();
    run_vec("right_68", 8'b0110_1000, 1'b1, 8'b0000_1101, 3'd3, 1'b0);
    run_vec("right_80", 8'h80, 1'b1, 8'h01, 3'd7, 1'b0);
  endtask

  task automatic test_edges();
    run_vec("zero_left",  8'h00, 1'b0, 8'h00, 3'd0, 1'b1);
    run_vec("zero_right", 8'h00, 1'b1, 8'h00, 3'd0, 1'b1);
    run_vec("msb_left",   8'h80, 1'b0, 8'h80, 3'd0, 1'b0);
    run_vec("lsb_left",   8'h01, 1'b0, 8'h80, 3'd7, 1'b0);
    run_vec("lsb_right",  8'h01, 1'b1, 8'h01, 3'd0, 1'b0);
  endtask

  // out_ready held high: IDLE -> SHIFT -> DONE -> IDLE, 3 cycles for k=0.
  task automatic test_back_to_back();
    @(negedge clk);
    bus.out_ready = 1'b1;
    start_op(8'h80, 1'b0);
    n_total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b00)
      $display("FAIL b2b_shift: got rdy=%b vld=%b want 0 0", bus.in_ready, bus.out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b01)
      $display("FAIL b2b_done: got rdy=%b vld=%b want 0 1", bus.in_ready, bus.out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10)
      $display("FAIL b2b_idle: got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
    else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    start_op(8'b0001_0110, 1'b0);
    wait_done(lat);
    bad = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'h01;
    bus.s0       = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if ({bus.out_valid, bus.in_ready, bus.b, bus.amt, bus.zero} !== {1'b1, 1'b0, 8'hB0, 3'd3, 1'b0})
        bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL backpressure_hold: got %0d unstable cycles want 0", bad);
    else n_pass++;
    bus.in_valid = 1'b0;
    finish_op();
    n_total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10)
      $display("FAIL backpressure_release: got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
    else n_pass++;
    run_vec("after_bp", 8'h20, 1'b1, 8'h01, 3'd5, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen;
    start_op(8'h01, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.out_valid, bus.in_ready, bus.b, bus.amt} !== {1'b0, 1'b1, 8'h00, 3'd0})
      $display("FAIL reset_mid: got vld=%b rdy=%b b=%h amt=%0d want 0 1 00 0",
               bus.out_valid, bus.in_ready, bus.b, bus.amt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || !bus.in_ready) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL reset_mid_stale: got %0d busy cycles want 0", seen);
    else n_pass++;
  endtask

  // Left-normalize then right-shift by amt must reproduce the operand.
  task automatic test_round_trip();
    logic [7:0] av;
    int lat;
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      av = 8'($urandom_range(1, 255));
      start_op(av, 1'b0);
      wait_done(lat);
      if (((bus.b >> bus.amt) !== av) || (bus.b[7] !== 1'b1) ||
          (int'(bus.amt) != clz8(av)) || (bus.zero !== 1'b0)) begin
        bad++;
        if (bad <= 4)
          $display("FAIL round_trip a=%h: got b=%h amt=%0d want amt=%0d", av, bus.b, bus.amt, clz8(av));
      end
      finish_op();
    end
    n_total++;
    if (bad != 0) $display("FAIL round_trip_total: got %0d bad operands want 0", bad);
    else n_pass++;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.s0        = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_left();
    test_right();
    test_edges();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
